// File: rtl/sync_hs_pkg.sv
// Shared definitions for the 4-phase bundled-data handshake blocks.
// State encodings are fixed because receive-side blocks decode them too.
package sync_hs_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SETUP = 2'b01;
  localparam logic [1:0] REQ   = 2'b10;
  localparam logic [1:0] REL   = 2'b11;

  localparam int unsigned DEFAULT_DW = 8;

endpackage

// File: rtl/sync2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sync_tx_arbiter.sv
// Round-robin arbiter feeding one 4-phase req/ack transmit channel.
// Requests are only evaluated in IDLE; one grant per full handshake.
module sync_tx_arbiter
  import sync_hs_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = DEFAULT_DW,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    v_i,
  input  logic [N_REQ*DW-1:0] d_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [IW-1:0]       src_o,
  output logic                busy_o,
  output logic                req_o,
  output logic [DW-1:0]       data_o,
  input  logic                ack_i
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(N_REQ);
  localparam logic [IW:0] ONE_W  = (IW+1)'(1);

  logic              a2;
  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     src_q, src_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              req_q, req_d;
  logic [DW-1:0]     data_q, data_d;

  logic              found;
  logic [IW-1:0]     win;
  logic [IW:0]       sum;
  logic [IW:0]       win_inc;
  logic [IW-1:0]     rr_next;
  logic [N_REQ-1:0]  win_onehot;
  logic [DW-1:0]     data_sel;

  sync2ff u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (ack_i),
    .q_o   (a2)
  );

  // Scan from rr_q upward with wrap; first hit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_q} + (IW+1)'(i);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      if (!found && v_i[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    win_inc = {1'b0, win} + ONE_W;
    rr_next = (win_inc == NREQ_W) ? '0 : win_inc[IW-1:0];
  end

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  always_comb begin
    data_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (IW'(k) == win) begin
        data_sel = d_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    gnt_d   = '0;
    req_d   = req_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        // A stale ack from the previous transfer blocks new grants.
        if (found && !a2) begin
          data_d  = data_sel;
          src_d   = win;
          gnt_d   = win_onehot;
          rr_d    = rr_next;
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        req_d = 1'b1;
        if (a2) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        req_d = 1'b0;
        if (!a2) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      src_q   <= '0;
      gnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign src_o  = src_q;
  assign req_o  = req_q;
  assign data_o = data_q;
  assign busy_o = (state_q != IDLE);

  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt_q));
  a_gnt_in_setup : assert property (@(posedge clk) disable iff (reset)
    (state_q == SETUP) == (|gnt_q));
  a_req_in_req : assert property (@(posedge clk) disable iff (reset)
    req_q == (state_q == REQ));

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Randomized bench for sync_tx_arbiter against a transfer-level reference model.
module tb_sync_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    v_i;
  logic [N*DW-1:0] d_i;
  logic [N-1:0]    gnt_o;
  logic [1:0]      src_o;
  logic            busy_o;
  logic            req_o;
  logic [DW-1:0]   data_o;
  logic            ack_i;
  logic            loop_en;
  logic            ack_man;

  assign ack_i = loop_en ? req_o : ack_man;

  sync_tx_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .v_i    (v_i),
    .d_i    (d_i),
    .gnt_o  (gnt_o),
    .src_o  (src_o),
    .busy_o (busy_o),
    .req_o  (req_o),
    .data_o (data_o),
    .ack_i  (ack_i)
  );

  always #5 clk = ~clk;

  int            n_chk;
  int            n_fail;
  int            rr_m;
  logic [DW-1:0] dword [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [DW-1:0] val);
    dword[k] = val;
    d_i[k*DW +: DW] = val;
  endtask

  task automatic shuffle_words();
    for (int k = 0; k < N; k++) set_word(k, DW'($urandom));
  endtask

  // Reference arbitration: first active requester at or after the pointer.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic wait_grant(input int limit, output int lat, output logic [31:0] busy_h,
                            output logic [31:0] req_h, output logic moved);
    logic [DW-1:0] d0;
    d0 = data_o; lat = 0; busy_h = '0; req_h = '0; moved = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat < 32) begin
        busy_h[lat] = busy_o;
        req_h[lat]  = req_o;
      end
      if (gnt_o == '0 && data_o !== d0) moved = 1'b1;
    end while (gnt_o == '0 && lat < limit);
  endtask

  task automatic score_grant(input string tag, input logic [N-1:0] v, input int lat,
                             input int lat_exp, output int w);
    w = rr_pick(v, rr_m);
    check({tag, ".gnt"},  32'(gnt_o),  32'(1) << w);
    check({tag, ".src"},  32'(src_o),  32'(w));
    check({tag, ".data"}, 32'(data_o), 32'(dword[w]));
    check({tag, ".lat"},  32'(lat),    32'(lat_exp));
    rr_m = (w + 1) % N;
  endtask

  // Loopback: req high 1..3 cycles after grant, IDLE (busy low) at cycle 7.
  task automatic check_loop_shape(input string tag, input logic [31:0] bh,
                                  input logic [31:0] rh, input logic moved);
    check({tag, ".busy"}, 32'(bh[7:1]), 32'(7'b0111111));
    check({tag, ".req"},  32'(rh[7:1]), 32'(7'b0000111));
    check({tag, ".stable"}, 32'(moved), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    int            w;
    logic [31:0]   bh;
    logic [31:0]   rh;
    logic          moved;
    logic          any;
    logic          bad;
    logic [DW-1:0] dsnap;

    n_chk = 0; n_fail = 0; rr_m = 0;
    loop_en = 1'b0; ack_man = 1'b1; reset = 1'b1; v_i = '1;
    shuffle_words();

    repeat (3) @(negedge clk);
    check("rst.req",  32'(req_o),  32'(0));
    check("rst.gnt",  32'(gnt_o),  32'(0));
    check("rst.data", 32'(data_o), 32'(0));
    check("rst.busy", 32'(busy_o), 32'(0));
    check("rst.src",  32'(src_o),  32'(0));

    // Let the synchronizer see the stale ack before anyone requests.
    v_i = '0; reset = 1'b0;
    repeat (3) @(negedge clk);
    v_i = '1;
    any = 1'b0;
    repeat (5) begin @(negedge clk); any |= |gnt_o; end
    check("rst.stale_nogrant", 32'(any), 32'(0));
    ack_man = 1'b0;
    wait_grant(20, lat, bh, rh, moved);
    score_grant("rst.first", v_i, lat, 3, w);
    v_i[w] = 1'b0;

    // Slow receiver.
    dsnap = data_o; bad = 1'b0;
    @(negedge clk);
    check("slow.req_rise", 32'(req_o), 32'(1));
    repeat (19) begin @(negedge clk); if (data_o !== dsnap || !req_o) bad = 1'b1; end
    ack_man = 1'b1; lat = 0;
    do begin
      @(negedge clk); lat++;
      if (data_o !== dsnap) bad = 1'b1;
    end while (req_o && lat < 20);
    check("slow.req_fall_lat", 32'(lat), 32'(3));
    repeat (15) begin @(negedge clk); if (data_o !== dsnap || req_o || !busy_o) bad = 1'b1; end
    check("slow.hold", 32'(bad), 32'(0));
    ack_man = 1'b0;
    wait_grant(40, lat, bh, rh, moved);
    check("slow.stable", 32'(moved), 32'(0));
    score_grant("slow.next", v_i, lat, 4, w);
    v_i[w] = 1'b0;

    // Loopback from here on.
    loop_en = 1'b1;
    wait_grant(40, lat, bh, rh, moved);
    score_grant("loop1", v_i, lat, 8, w);
    check_loop_shape("loop1", bh, rh, moved);
    shuffle_words();

    v_i = '1;
    for (int r = 0; r < 5; r++) begin
      wait_grant(40, lat, bh, rh, moved);
      score_grant($sformatf("rr%0d", r), v_i, lat, 8, w);
      check_loop_shape($sformatf("rr%0d", r), bh, rh, moved);
      shuffle_words();
    end

    // Asynchronous reset while the request is up.
    repeat (2) @(negedge clk);
    check("mid.req_before", 32'(req_o), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("mid.req",  32'(req_o),  32'(0));
    check("mid.data", 32'(data_o), 32'(0));
    check("mid.gnt",  32'(gnt_o),  32'(0));
    check("mid.src",  32'(src_o),  32'(0));
    check("mid.busy", 32'(busy_o), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    v_i = N'($urandom_range(1, (1 << N) - 1));
    rr_m = 0;
    wait_grant(10, lat, bh, rh, moved);
    score_grant("mid.post", v_i, lat, 1, w);

    for (int r = 0; r < 8; r++) begin
      v_i[w] = 1'b0;
      v_i |= N'($urandom);
      if (v_i == '0) v_i = N'(1 << $urandom_range(0, N - 1));
      shuffle_words();
      wait_grant(40, lat, bh, rh, moved);
      score_grant($sformatf("rand%0d", r), v_i, lat, 8, w);
      check_loop_shape($sformatf("rand%0d", r), bh, rh, moved);
    end

    // Stale ack while idle.
    v_i = '0;
    repeat (10) @(negedge clk);
    loop_en = 1'b0; ack_man = 1'b1;
    repeat (4) @(negedge clk);
    v_i = N'(1);
    any = 1'b0;
    repeat (6) begin @(negedge clk); any |= |gnt_o | busy_o; end
    check("stale.nogrant", 32'(any), 32'(0));
    ack_man = 1'b0;
    wait_grant(10, lat, bh, rh, moved);
    score_grant("stale.grant", v_i, lat, 3, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
